// File: rtl/mdu_exe.sv
// Execute-stage RISC-V M-extension unit: 2-cycle multiply, 33-cycle radix-2
// restoring divide, with a hold request upstream and a one-cycle write-back.
module mdu_exe #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic           i_valid,
  input  logic [7:0]     i_instr_m,
  input  logic [DW-1:0]  i_rs_1_data,
  input  logic [DW-1:0]  i_rs_2_data,
  input  logic [RAW-1:0] i_rd,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_rd_en,
  output logic [RAW-1:0] o_rd,
  output logic [DW-1:0]  o_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [7:0]     op_q, op_d;
  logic [RAW-1:0] rd_q, rd_d;
  logic [DW-1:0]  opa_q, opa_d;   // multiplicand, or dividend magnitude shifting into quotient
  logic [DW-1:0]  opb_q, opb_d;   // multiplier, or divisor magnitude
  logic [DW-1:0]  rem_q, rem_d;
  logic [DW-1:0]  result_q, result_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;

  logic                    start, in_signed_div, in_rem, a_neg, b_neg, div_zero, div_ovf;
  logic signed [2*DW+1:0]  mul_a, mul_b, product;
  logic [DW:0]             rem_shift, diff;
  logic                    qbit;
  logic [DW-1:0]           rem_next, quo_next;

  always_comb begin
    start         = (state_q == S_IDLE) && i_valid && (|i_instr_m) && !i_flush && !rst;
    in_signed_div = i_instr_m[4] | i_instr_m[6];
    in_rem        = i_instr_m[6] | i_instr_m[7];
    a_neg         = in_signed_div & i_rs_1_data[DW-1];
    b_neg         = in_signed_div & i_rs_2_data[DW-1];
    div_zero      = (i_rs_2_data == '0);
    div_ovf       = in_signed_div && (i_rs_1_data == {1'b1, {(DW-1){1'b0}}})
                    && (i_rs_2_data == '1);

    // Operands sign- or zero-extended per op; one wide signed multiply covers all four.
    mul_a   = {{(DW+2){(op_q[1] | op_q[2]) & opa_q[DW-1]}}, opa_q};
    mul_b   = {{(DW+2){op_q[1] & opb_q[DW-1]}}, opb_q};
    product = mul_a * mul_b;

    rem_shift = {rem_q, opa_q[DW-1]};
    diff      = rem_shift - {1'b0, opb_q};
    qbit      = !diff[DW];
    rem_next  = qbit ? diff[DW-1:0] : rem_shift[DW-1:0];
    quo_next  = {opa_q[DW-2:0], qbit};
  end

  // NOTE: every next-state signal gets its default first so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    result_d = result_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = i_instr_m;
          rd_d   = i_rd;
          cnt_d  = '0;
          rem_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (|i_instr_m[3:0]) begin
            opa_d   = i_rs_1_data;
            opb_d   = i_rs_2_data;
            state_d = S_MUL;
          end else if (div_zero) begin
            result_d = in_rem ? i_rs_1_data : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = in_rem ? '0 : i_rs_1_data;
            state_d  = S_DONE;
          end else begin
            opa_d   = a_neg ? -i_rs_1_data : i_rs_1_data;
            opb_d   = b_neg ? -i_rs_2_data : i_rs_2_data;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = op_q[0] ? product[DW-1:0] : product[2*DW-1:DW];
        state_d  = S_DONE;
      end
      S_DIV: begin
        opa_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          if (op_q[6] | op_q[7]) result_d = rneg_q ? -rem_next : rem_next;
          else                   result_d = qneg_q ? -quo_next : quo_next;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  always_comb begin
    o_busy    = start || (state_q == S_MUL) || (state_q == S_DIV);
    o_done    = (state_q == S_DONE) && !i_flush;
    o_rd_en   = o_done && (|rd_q);
    o_rd      = o_done ? rd_q : '0;
    o_rd_data = o_done ? result_q : '0;
  end

endmodule

// File: tb/tb_mdu_exe.sv
// Scoreboard bench for mdu_exe: directed and random M ops against an
// arithmetic reference model, with flush and mid-operation reset scenarios.
`timescale 1ns/1ps
module tb_mdu_exe;

  localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
  localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush, i_valid;
  logic [7:0]  i_instr_m;
  logic [31:0] i_rs_1_data, i_rs_2_data;
  logic [4:0]  i_rd;
  logic        o_busy, o_done, o_rd_en;
  logic [4:0]  o_rd;
  logic [31:0] o_rd_data;

  mdu_exe #(.DW(32), .RAW(5)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_instr_m(i_instr_m), .i_rs_1_data(i_rs_1_data), .i_rs_2_data(i_rs_2_data),
    .i_rd(i_rd), .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
    .o_rd(o_rd), .o_rd_data(o_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rd_en;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit and SV integer arithmetic from the RISC-V M rules.
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    longint sa, sb, p;
    int     ia, ib;
    logic   sgn, is_rem;
    logic [31:0] q, r;
    if (op < 4) begin
      sa  = (op == OP_MULH || op == OP_MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
      sb  = (op == OP_MULH) ? longint'($signed(b)) : longint'({32'b0, b});
      p   = sa * sb;
      res = (op == OP_MUL) ? p[31:0] : p[63:32];
      lat = 2;
    end else begin
      sgn    = (op == OP_DIV || op == OP_REM);
      is_rem = (op >= OP_REM);
      ia = a;
      ib = b;
      if (b == 0) begin
        q = 32'hFFFF_FFFF; r = a; lat = 1;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 0; lat = 1;
      end else if (sgn) begin
        q = ia / ib; r = ia % ib; lat = 33;
      end else begin
        q = a / b; r = a % b; lat = 33;
      end
      res = is_rem ? r : q;
    end
  endfunction

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (o_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {59'b0, o_rd}, 64'hFFFF);
      end else begin
        e = sb_q.pop_front();
        check("rd_data", {32'b0, o_rd_data}, {32'b0, e.data});
        check("rd", {59'b0, o_rd}, {59'b0, e.rd});
        check("rd_en", {63'b0, o_rd_en}, {63'b0, e.rd_en});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_in_done", {63'b0, o_busy}, 64'b0);
      end
    end else if (o_rd_en || o_rd != 0 || o_rd_data != 0) begin
      check("idle_outputs", {o_rd_en, 26'b0, o_rd, o_rd_data}, 64'b0);
    end
  end

  // Called #1 after a rising edge; leaves at #3 after the next rising edge.
  task automatic start_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit push, output int t);
    logic [31:0] res;
    int          lat;
    exp_t        e;
    model(op, a, b, res, lat);
    t = cyc;
    if (push) begin
      e.rd = rd; e.data = res; e.rd_en = (rd != 0); e.cyc = t + lat;
      sb_q.push_back(e);
    end
    i_valid     = 1'b1;
    i_instr_m   = 8'(1 << op);
    i_rs_1_data = a;
    i_rs_2_data = b;
    i_rd        = rd;
    #1 check("busy_at_start", {63'b0, o_busy}, 64'b1);
    @(posedge clk);
    #1;
    i_valid   = 1'b0;
    i_instr_m = '0;
    #1 check("busy_after_start", {63'b0, o_busy}, {63'b0, (lat > 1)});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb_q.size() > 0) begin
      check("timeout_pending", 64'(sb_q.size()), 64'b0);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int t;
    start_op(op, a, b, rd, 1'b1, t);
    wait_drain();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {o_busy, o_done, o_rd_en, 24'b0, o_rd, o_rd_data}, 64'b0);
  endtask

  initial begin
    int t;
    logic [31:0] a, b;
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_instr_m = '0;
    i_rs_1_data = '0; i_rs_2_data = '0; i_rd = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5);
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd3);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd6);
    run_op(OP_DIVU,   32'd100,        32'd7,         5'd7);
    run_op(OP_REMU,   32'd100,        32'd7,         5'd8);
    run_op(OP_DIVU,   32'h1234,       32'd0,         5'd9);
    run_op(OP_REM,    32'h1234,       32'd0,         5'd10);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12);
    run_op(OP_DIV,    32'd55,         32'd5,         5'd0);

    // Flush part-way through a divide, then a multiply straight after.
    start_op(OP_DIV, 32'd1000, 32'd3, 5'd13, 1'b0, t);
    while (cyc < t + 10) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    #1 check("busy_after_flush", {63'b0, o_busy}, 64'b0);
    run_op(OP_MUL, 32'd12, 32'd13, 5'd14);

    // Reset part-way through a divide: outputs clear at once, no result later.
    start_op(OP_DIV, 32'd1000, 32'd3, 5'd15, 1'b0, t);
    while (cyc < t + 5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1 check_all_zero("reset_mid_op");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(op, a, b, 5'($urandom_range(0, 31)));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_exe.md
Name: mdu_exe

Overview:
- Execute-stage M-extension unit that sits directly downstream of the decode/forward pipeline register.
- Consumes the registered rs1/rs2 operand data, the one-hot M-instruction vector and rd.
- Multiplies in 2 cycles; divides/remainders with a radix-2 restoring iterative divider (33 cycles).
- Raises a hold request so the front-end and decode/forward stage freeze while it works, then presents a one-cycle write-back result.

Parameters:
- DW, 32, operand/result width.
- RAW, 5, register address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_flush  input  1  jump/flush from branch resolution; synchronous abort.
- i_valid  input  1  execute-stage instruction valid.
- i_instr_m  input  8  one-hot M op: bit0 MUL, bit1 MULH, bit2 MULHSU, bit3 MULHU, bit4 DIV, bit5 DIVU, bit6 REM, bit7 REMU.
- i_rs_1_data  input  DW  forwarded rs1 value.
- i_rs_2_data  input  DW  forwarded rs2 value.
- i_rd  input  RAW  destination register.
- o_busy  output  1  hold request to upstream stages.
- o_done  output  1  result valid, exactly one cycle.
- o_rd_en  output  1  write-back enable.
- o_rd  output  RAW  write-back register.
- o_rd_data  output  DW  write-back data.

Behaviour:
- Reset (async, rst=1): state=IDLE; o_busy, o_done, o_rd_en = 0; o_rd = 0; o_rd_data = 0; counter, operand and result registers = 0.
- Start condition: state==IDLE && i_valid && |i_instr_m && !i_flush.
- i_instr_m with more than one bit set is illegal input and is not checked.
- On start, latch operands, op, and rd.
- States:
  - IDLE: on start, go to MUL for bits 0-3, or DIV for bits 4-7. A division by zero or a signed overflow goes straight to DONE instead.
  - MUL: form 33x33 signed product with operands extended per op. MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/MUL: both unsigned. MUL returns bits[31:0]; MULH* return bits[63:32]. Next state is DONE.
  - DIV: iterate on operand magnitudes (signed ops take absolute values), one quotient bit per cycle, counter 0..31. When counter==31, go to DONE and apply sign fix: quotient negated when signed op and operand signs differ; remainder takes the sign of the dividend.
  - DONE: o_done=1, o_rd=latched rd, o_rd_en=(rd!=0), o_rd_data=result. Return to IDLE unconditionally. i_valid is ignored in DONE (upstream advances at the end of this cycle).
- Special cases, resolved in the IDLE start cycle, with the result ready in DONE at T+1:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Latency (start accepted at cycle T): MUL-class, o_done at T+2. Normal divide, o_done at T+33. Special case, o_done at T+1.
- o_busy is combinational:
  - high at T (start cycle),
  - high in every MUL and DIV cycle,
  - low in DONE and in IDLE without a start.
- o_rd_en, o_rd, o_rd_data are 0 whenever o_done=0.
- i_flush, any state: next state IDLE, counter cleared, no o_done produced. o_busy is driven low in the same cycle if state is IDLE; otherwise it goes low the next cycle.
- i_flush while in DONE: o_done in that cycle is suppressed (forced 0).
- rst asserted mid-operation: immediate return to reset values; no partial result is emitted.
- Back-to-back M ops: the second op starts from IDLE on the cycle after DONE. There is no bubble beyond that.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> o_busy high at T and T+1; at T+2 o_done=1, o_rd=5, o_rd_data=0xFFFFFFEB; o_busy low at T+2.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF. Each at T+2.
- DIV -7/2 -> 0xFFFFFFFD, and REM -7/2 -> 0xFFFFFFFF, o_done at T+33. DIVU 100/7 -> 14, and REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All at T+1.
- i_flush asserted at T+10 of a DIV -> no o_done; o_busy low at T+11. A new MUL started at T+11 completes at T+13.
- DIV with rd=0 -> o_done=1 at T+33 with o_rd_en=0. rst pulsed at T+5 of a divide -> all outputs 0 immediately; no o_done afterwards.
